pc_next_sequencer: RTL and testbench
====================================

# pc_next_sequencer

Generates the `nextPC` value consumed by the program counter register each cycle. It also owns the boot hold-off, halt state, exception redirect and the EPC register. It sits between the control/ALU outputs and the PC register of the single-cycle MIPS core. It drives the PC register's `nextPC` input and reads back its `PC` output.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, address fetched after boot.
- `EXC_VECTOR`, 32'h0000_0180, exception handler address.
- `BOOT_CYCLES`, 2, cycles `nextPC` is held at `RESET_VECTOR` after reset release (must be ≥1).

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `PC`  in  32  current PC from the PC register.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_offset`  in  32  sign-extended 16-bit immediate (word offset).
- `jump`  in  1  J/JAL.
- `jump_target`  in  26  instr[25:0].
- `jump_reg`  in  1  JR/JALR.
- `reg_target`  in  32  rs value for JR.
- `exception`  in  1  synchronous exception request from decode/ALU.
- `eret`  in  1  return from exception.
- `halt`  in  1  halt request (syscall/break).
- `stall`  in  1  hold current PC.
- `nextPC`  out  32  next PC value (combinational).
- `epc`  out  32  exception PC register.
- `misaligned`  out  1  registered one-cycle pulse: a redirect target had bits [1:0] ≠ 0.
- `state`  out  2  0=BOOT, 1=RUN, 2=HALTED.

## Operation
- Arithmetic, all mod 2^32:
  - pc4 = PC+4.
  - branch target = pc4 + (branch_offset<<2).
  - jump target = {pc4[31:28], jump_target, 2'b00}.
  - JR target = reg_target.
- FSM:
  - BOOT: nextPC=RESET_VECTOR; counter counts BOOT_CYCLES rising edges, then RUN. All inputs ignored.
  - RUN: nextPC from the priority chain below.
  - HALTED: nextPC=PC; all inputs ignored; exit only via `reset`.
- RUN priority, highest first:
  - exception: nextPC=EXC_VECTOR; epc<=PC.
  - halt: nextPC=PC; state<=HALTED.
  - eret: nextPC=epc.
  - stall: nextPC=PC.
  - jump_reg: nextPC=reg_target.
  - jump: nextPC=jump target.
  - branch_taken: nextPC=branch target.
  - otherwise: nextPC=pc4.
- Misaligned redirect:
  - Applies when the selected jump_reg/branch target or the eret epc has bits [1:0] ≠ 0.
  - The redirect is replaced by the exception action: nextPC=EXC_VECTOR, epc<=PC, misaligned pulses high the next cycle.
  - Sequential pc4 is never checked.
- epc changes only on an exception or misaligned redirect.

## Timing
- `nextPC` is combinational, valid in the same cycle as its inputs. The PC register captures it at the next rising edge, so redirect latency is 1 edge.
- `epc`, `state` and `misaligned` update on the rising edge that accepts the event.
- Reset (`reset`=0), asynchronous:
  - state=BOOT, boot counter=0, epc=0, misaligned=0.
  - nextPC=RESET_VECTOR, valid immediately without a clock.
- Reset release: nextPC stays RESET_VECTOR for exactly BOOT_CYCLES edges; RUN is entered on the last of them.
- Reset asserted mid-operation (RUN or HALTED): immediate return to BOOT. epc is cleared and a pending misaligned pulse is dropped.
- Simultaneous inputs are resolved strictly by the priority list. Examples:
  - exception+halt: exception is taken, state stays RUN.
  - stall+branch_taken: the stall wins, and the branch must be re-presented.
- exception and eret in the same cycle: exception wins, and epc<=PC, not the old epc.
- Wrap-around:
  - PC=32'hFFFF_FFFC gives pc4=0.
  - A negative offset below 0 wraps modulo 2^32 with no flag.

## Test plan
- Boot: hold reset low 100 ns, then release with BOOT_CYCLES=2 -> nextPC=0 for 2 edges, state=1 after the 2nd edge.
- Sequential and wrap: PC=0x0000_0010 -> nextPC=0x14; PC=0xFFFF_FFFC -> nextPC=0.
- Control flow, each with PC=0x0040_0020:
  - branch_taken with offset=32'hFFFF_FFFE -> nextPC=0x0040_001C.
  - jump with target=26'h000_0100 -> nextPC=0x0000_0400.
  - jump_reg with reg_target=0x1234_5678 plus branch_taken -> nextPC=0x1234_5678.
- Exception/eret:
  - exception at PC=0x80 -> nextPC=0x180, epc=0x80 after the edge.
  - Then eret -> nextPC=0x80.
  - jump_reg to 0x1002 -> nextPC=0x180, misaligned=1 for one cycle, epc=PC.
- Halt and stall:
  - stall at PC=0x40 -> nextPC=0x40, state=1.
  - halt -> state=2; branch, jump and exception afterwards are ignored, nextPC=PC.
- Reset mid-run: assert reset between edges while in HALTED with epc≠0 -> nextPC=RESET_VECTOR, epc=0, state=0 with no clock edge.

Source files
------------

// File: rtl/pc_next_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sequencer_if
// Description : Control/ALU-side bundle into the next-PC sequencer and its
//               results back toward the PC register.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_next_sequencer_if;
  logic [31:0] PC;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic        exception;
  logic        eret;
  logic        halt;
  logic        stall;
  logic [31:0] nextPC;
  logic [31:0] epc;
  logic        misaligned;
  logic [1:0]  state;

  modport master (
    output PC, branch_taken, branch_offset, jump, jump_target, jump_reg,
           reg_target, exception, eret, halt, stall,
    input  nextPC, epc, misaligned, state
  );

  modport slave (
    input  PC, branch_taken, branch_offset, jump, jump_target, jump_reg,
           reg_target, exception, eret, halt, stall,
    output nextPC, epc, misaligned, state
  );
endinterface
`default_nettype wire

// File: rtl/pc_next_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_sequencer
// Description : Combinational nextPC selection with boot hold-off, halt,
//               exception redirect and EPC register.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  pc_next_sequencer_if.slave bus
);

  localparam logic [1:0] c_st_boot   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_halted = 2'd2;

  localparam int c_cnt_w = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_boot_last = c_cnt_w'(BOOT_CYCLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_boot_cnt;
  logic [31:0]        r_epc;
  logic               r_misaligned;

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_next_pc;
  logic        w_take_exc;
  logic        w_mis_set;

  assign w_pc4    = bus.PC + 32'd4;
  assign w_br_tgt = w_pc4 + (bus.branch_offset << 2);
  assign w_j_tgt  = {w_pc4[31:28], bus.jump_target, 2'b00};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_boot;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; exception outranks halt
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_boot:   if (r_boot_cnt == c_boot_last) w_state_nxt = c_st_run;
      c_st_run:    if (bus.halt && !bus.exception) w_state_nxt = c_st_halted;
      c_st_halted: w_state_nxt = c_st_halted;
      default:     w_state_nxt = c_st_boot;
    endcase
  end

  // Output logic: RUN priority chain with misaligned redirect folded into exception
  always_comb begin
    w_next_pc  = RESET_VECTOR;
    w_take_exc = 1'b0;
    w_mis_set  = 1'b0;
    case (r_state)
      c_st_boot:   w_next_pc = RESET_VECTOR;
      c_st_halted: w_next_pc = bus.PC;
      c_st_run: begin
        if (bus.exception) begin
          w_take_exc = 1'b1;
        end else if (bus.halt) begin
          w_next_pc = bus.PC;
        end else if (bus.eret) begin
          if (r_epc[1:0] != 2'b00) w_mis_set = 1'b1;
          else                     w_next_pc = r_epc;
        end else if (bus.stall) begin
          w_next_pc = bus.PC;
        end else if (bus.jump_reg) begin
          if (bus.reg_target[1:0] != 2'b00) w_mis_set = 1'b1;
          else                              w_next_pc = bus.reg_target;
        end else if (bus.jump) begin
          w_next_pc = w_j_tgt;
        end else if (bus.branch_taken) begin
          if (w_br_tgt[1:0] != 2'b00) w_mis_set = 1'b1;
          else                        w_next_pc = w_br_tgt;
        end else begin
          w_next_pc = w_pc4;
        end
        if (w_mis_set) w_take_exc = 1'b1;
        if (w_take_exc) w_next_pc = EXC_VECTOR;
      end
      default: w_next_pc = RESET_VECTOR;
    endcase
  end

  // Boot counter, EPC and misaligned pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_boot_cnt   <= '0;
      r_epc        <= 32'd0;
      r_misaligned <= 1'b0;
    end else begin
      if (r_state == c_st_boot && r_boot_cnt != c_boot_last) begin
        r_boot_cnt <= r_boot_cnt + 1'b1;
      end
      if (w_take_exc) begin
        r_epc <= bus.PC;
      end
      r_misaligned <= w_mis_set;
    end
  end

  assign bus.nextPC     = w_next_pc;
  assign bus.epc        = r_epc;
  assign bus.misaligned = r_misaligned;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_next_sequencer
// Description : Directed and randomized checks of pc_next_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_sequencer;

  localparam logic [31:0] c_rv = 32'h0000_0000;
  localparam logic [31:0] c_ev = 32'h0000_0180;
  localparam int          c_bc = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_next_sequencer_if bus ();

  pc_next_sequencer #(
    .RESET_VECTOR(c_rv),
    .EXC_VECTOR  (c_ev),
    .BOOT_CYCLES (c_bc)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: 0 boot, 1 run, 2 halted
  logic [1:0]  m_state;
  logic [31:0] m_epc;
  bit          m_mis;
  int          m_boot_left;

  logic [31:0] e_np;
  bit          e_exc, e_mis, e_hlt;

  task automatic model_reset();
    m_state     = 2'd0;
    m_epc       = 32'd0;
    m_mis       = 1'b0;
    m_boot_left = c_bc;
  endtask

  task automatic model_eval(output logic [31:0] np, output bit exc,
                            output bit mis, output bit hlt);
    logic [31:0] pc4, tgt;
    bit checked;
    np = bus.PC; exc = 0; mis = 0; hlt = 0;
    pc4 = bus.PC + 32'd4;
    checked = 0;
    tgt = pc4;
    if (m_state == 2'd0) begin
      np = c_rv;
    end else if (m_state == 2'd1) begin
      if (bus.exception) exc = 1;
      else if (bus.halt) hlt = 1;
      else if (bus.eret) begin
        if (m_epc % 4 != 0) mis = 1;
        else np = m_epc;
      end else if (bus.stall) np = bus.PC;
      else begin
        if (bus.jump_reg) begin
          tgt = bus.reg_target; checked = 1;
        end else if (bus.jump) begin
          tgt = (pc4 & 32'hF000_0000) | (32'(bus.jump_target) * 4);
        end else if (bus.branch_taken) begin
          tgt = pc4 + bus.branch_offset * 4; checked = 1;
        end
        if (checked && (tgt % 4 != 0)) mis = 1;
        else np = tgt;
      end
      if (mis) exc = 1;
      if (exc) np = c_ev;
    end
  endtask

  task automatic model_clock(input bit exc, input bit mis, input bit hlt);
    case (m_state)
      2'd0: begin
        m_boot_left--;
        if (m_boot_left == 0) m_state = 2'd1;
        m_mis = 0;
      end
      2'd1: begin
        if (exc) m_epc = bus.PC;
        m_mis = mis;
        if (hlt) m_state = 2'd2;
      end
      default: m_mis = 0;
    endcase
  endtask

  task automatic tick();
    model_eval(e_np, e_exc, e_mis, e_hlt);
    @(posedge clk);
    model_clock(e_exc, e_mis, e_hlt);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input bit br, input logic [31:0] off,
                        input bit j, input logic [25:0] jt, input bit jr,
                        input logic [31:0] rt, input bit exc, input bit er,
                        input bit hl, input bit st);
    bus.PC = pc; bus.branch_taken = br; bus.branch_offset = off;
    bus.jump = j; bus.jump_target = jt; bus.jump_reg = jr; bus.reg_target = rt;
    bus.exception = exc; bus.eret = er; bus.halt = hl; bus.stall = st;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    set_in(pc, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set_pc(32'h0000_1234);
    model_reset();
    #1;
    tests++; if (bus.nextPC !== c_rv) begin fails++; $display("FAIL reset_nextpc: got %h want %h", bus.nextPC, c_rv); end
    tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    tests++; if (bus.epc !== 32'd0) begin fails++; $display("FAIL reset_epc: got %h want 0", bus.epc); end
    tests++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis: got %b want 0", bus.misaligned); end
    #99;
    reset = 1'b1;
  endtask

  task automatic test_boot();
    // Control inputs are active during boot and must be ignored
    set_in(32'h0000_0800, 1, 32'd4, 1, 26'h3, 1, 32'h0000_1002, 1, 1, 1, 0);
    tests++; if (bus.nextPC !== c_rv) begin fails++; $display("FAIL boot_np0: got %h want %h", bus.nextPC, c_rv); end
    tick();
    tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL boot_state1: got %0d want 0", bus.state); end
    tests++; if (bus.nextPC !== c_rv) begin fails++; $display("FAIL boot_np1: got %h want %h", bus.nextPC, c_rv); end
    tick();
    tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL boot_state2: got %0d want 1", bus.state); end
    tests++; if (bus.epc !== 32'd0) begin fails++; $display("FAIL boot_epc: got %h want 0", bus.epc); end
  endtask

  task automatic test_sequential();
    set_pc(32'h0000_0010); #4;
    tests++; if (bus.nextPC !== 32'h14) begin fails++; $display("FAIL seq_pc4: got %h want 00000014", bus.nextPC); end
    tick();
    set_pc(32'hFFFF_FFFC); #4;
    tests++; if (bus.nextPC !== 32'h0) begin fails++; $display("FAIL seq_wrap: got %h want 00000000", bus.nextPC); end
    tick();
    tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL seq_state: got %0d want 1", bus.state); end
  endtask

  task automatic test_control_flow();
    set_in(32'h0040_0020, 1, 32'hFFFF_FFFE, 0, 26'd0, 0, 32'd0, 0, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== 32'h0040_001C) begin fails++; $display("FAIL branch_back: got %h want 0040001c", bus.nextPC); end
    tick();
    set_in(32'h0040_0020, 0, 32'd0, 1, 26'h000_0100, 0, 32'd0, 0, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== 32'h0000_0400) begin fails++; $display("FAIL jump: got %h want 00000400", bus.nextPC); end
    tick();
    set_in(32'h0040_0020, 1, 32'd8, 0, 26'd0, 1, 32'h1234_5678, 0, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== 32'h1234_5678) begin fails++; $display("FAIL jr_over_branch: got %h want 12345678", bus.nextPC); end
    tick();
    tests++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL jr_no_mis: got %b want 0", bus.misaligned); end
  endtask

  task automatic test_exception();
    set_in(32'h0000_0080, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== c_ev) begin fails++; $display("FAIL exc_np: got %h want %h", bus.nextPC, c_ev); end
    tick();
    tests++; if (bus.epc !== 32'h80) begin fails++; $display("FAIL exc_epc: got %h want 00000080", bus.epc); end
    set_in(32'h0000_0180, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 1, 0, 0); #4;
    tests++; if (bus.nextPC !== 32'h80) begin fails++; $display("FAIL eret_np: got %h want 00000080", bus.nextPC); end
    tick();
    set_in(32'h0000_0200, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1, 1, 0, 0); #4;
    tests++; if (bus.nextPC !== c_ev) begin fails++; $display("FAIL exc_eret_np: got %h want %h", bus.nextPC, c_ev); end
    tick();
    tests++; if (bus.epc !== 32'h200) begin fails++; $display("FAIL exc_eret_epc: got %h want 00000200", bus.epc); end
    set_in(32'h0000_0300, 0, 32'd0, 0, 26'd0, 1, 32'h0000_1002, 0, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== c_ev) begin fails++; $display("FAIL jr_mis_np: got %h want %h", bus.nextPC, c_ev); end
    tick();
    tests++; if (bus.misaligned !== 1'b1) begin fails++; $display("FAIL jr_mis_pulse: got %b want 1", bus.misaligned); end
    tests++; if (bus.epc !== 32'h300) begin fails++; $display("FAIL jr_mis_epc: got %h want 00000300", bus.epc); end
    set_pc(32'h0000_0180); #4;
    tests++; if (bus.nextPC !== 32'h184) begin fails++; $display("FAIL post_mis_np: got %h want 00000184", bus.nextPC); end
    tick();
    tests++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL mis_one_cycle: got %b want 0", bus.misaligned); end
    // Branch from an unaligned PC yields an unaligned target
    set_in(32'h0000_0401, 1, 32'd1, 0, 26'd0, 0, 32'd0, 0, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== c_ev) begin fails++; $display("FAIL br_mis_np: got %h want %h", bus.nextPC, c_ev); end
    tick();
    tests++; if (bus.epc !== 32'h401) begin fails++; $display("FAIL br_mis_epc: got %h want 00000401", bus.epc); end
    set_in(32'h0000_0180, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 1, 0, 0); #4;
    tests++; if (bus.nextPC !== c_ev) begin fails++; $display("FAIL eret_mis_np: got %h want %h", bus.nextPC, c_ev); end
    tick();
    tests++; if (bus.misaligned !== 1'b1) begin fails++; $display("FAIL eret_mis_pulse: got %b want 1", bus.misaligned); end
    tests++; if (bus.epc !== 32'h180) begin fails++; $display("FAIL eret_mis_epc: got %h want 00000180", bus.epc); end
  endtask

  task automatic test_halt_stall();
    set_in(32'h0000_0040, 1, 32'd4, 0, 26'd0, 0, 32'd0, 0, 0, 0, 1); #4;
    tests++; if (bus.nextPC !== 32'h40) begin fails++; $display("FAIL stall_np: got %h want 00000040", bus.nextPC); end
    tick();
    tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL stall_state: got %0d want 1", bus.state); end
    set_in(32'h0000_0050, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1, 0, 1, 0); #4;
    tests++; if (bus.nextPC !== c_ev) begin fails++; $display("FAIL exc_halt_np: got %h want %h", bus.nextPC, c_ev); end
    tick();
    tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL exc_halt_state: got %0d want 1", bus.state); end
    tests++; if (bus.epc !== 32'h50) begin fails++; $display("FAIL exc_halt_epc: got %h want 00000050", bus.epc); end
    set_in(32'h0000_0060, 1, 32'd4, 0, 26'd0, 0, 32'd0, 0, 0, 1, 0); #4;
    tests++; if (bus.nextPC !== 32'h60) begin fails++; $display("FAIL halt_np: got %h want 00000060", bus.nextPC); end
    tick();
    tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL halt_state: got %0d want 2", bus.state); end
    set_in(32'h0000_0064, 1, 32'd4, 1, 26'h10, 0, 32'd0, 1, 0, 0, 0); #4;
    tests++; if (bus.nextPC !== 32'h64) begin fails++; $display("FAIL halted_np: got %h want 00000064", bus.nextPC); end
    tick();
    tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL halted_state: got %0d want 2", bus.state); end
    tests++; if (bus.epc !== 32'h50) begin fails++; $display("FAIL halted_epc: got %h want 00000050", bus.epc); end
  endtask

  task automatic reboot();
    set_pc(32'h0);
    tick();
    tick();
  endtask

  task automatic test_reset_midrun();
    // Currently HALTED with epc = 0x50
    reset = 1'b0;
    model_reset();
    #1;
    tests++; if (bus.nextPC !== c_rv) begin fails++; $display("FAIL midrst_np: got %h want %h", bus.nextPC, c_rv); end
    tests++; if (bus.epc !== 32'd0) begin fails++; $display("FAIL midrst_epc: got %h want 0", bus.epc); end
    tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL midrst_state: got %0d want 0", bus.state); end
    #1 reset = 1'b1;
    reboot();
    tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL reboot_state: got %0d want 1", bus.state); end
    // A pending misaligned pulse must be dropped by reset
    set_in(32'h0000_0100, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0003, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    tests++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL midrst_mis: got %b want 0", bus.misaligned); end
    #1 reset = 1'b1;
    reboot();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int halted_cycles;
    pc = 32'h0000_1000;
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      set_in(pc,
             $urandom_range(0, 3) == 0, 32'($signed(16'($urandom))),
             $urandom_range(0, 5) == 0, 26'($urandom),
             $urandom_range(0, 5) == 0,
             ($urandom_range(0, 4) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC),
             $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
             $urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0);
      #4;
      model_eval(e_np, e_exc, e_mis, e_hlt);
      tests++; if (bus.nextPC !== e_np) begin fails++; $display("FAIL rnd_np[%0d]: got %h want %h", i, bus.nextPC, e_np); end
      tick();
      pc = e_np;
      tests++; if (bus.state !== m_state) begin fails++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, bus.state, m_state); end
      tests++; if (bus.epc !== m_epc) begin fails++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, bus.epc, m_epc); end
      tests++; if (bus.misaligned !== m_mis) begin fails++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, bus.misaligned, m_mis); end
      halted_cycles = (m_state == 2'd2) ? halted_cycles + 1 : 0;
      if (halted_cycles >= 3) begin
        reset = 1'b0;
        model_reset();
        #1;
        tests++; if (bus.nextPC !== c_rv) begin fails++; $display("FAIL rnd_rst_np[%0d]: got %h want %h", i, bus.nextPC, c_rv); end
        reset = 1'b1;
        halted_cycles = 0;
        pc = c_rv;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot();
    test_sequential();
    test_control_flow();
    test_exception();
    test_halt_stall();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
